// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed voice mixer with saturation and linear pan.
//
// On sample_strobe the voice samples, gains and pan settings are captured.
// The captured voices are then accumulated one per clock through a single
// shared multiplier. The sum is saturated to W bits, optionally panned, and
// presented on registered ldata/rdata with a one-cycle out_valid pulse.
//
// Ports:
//   Clk, Reset_n   clock and asynchronous active-low reset
//   sample_strobe  one-cycle pulse: start a mix from the current inputs
//   voice_in       N_VOICES packed signed W-bit samples (voice i at [i*W +: W])
//   gain_in        N_VOICES packed unsigned GAIN_W-bit gains
//   pan_en, pan    pan enable and position (0x0000 left .. 0xFFFF right)
//   flag_clr       clears the sticky clip/overrun flags (a set wins)
//   ldata, rdata   registered left/right samples, held between updates
//   out_valid      one-cycle pulse when ldata/rdata update
//   busy           high while a mix is in progress
//   clip, overrun  sticky: saturation occurred / strobe arrived while busy
module voice_mixer #(
    parameter int N_VOICES = 8,
    parameter int W        = 16,
    parameter int GAIN_W   = 16
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       sample_strobe,
    input  logic [N_VOICES*W-1:0]      voice_in,
    input  logic [N_VOICES*GAIN_W-1:0] gain_in,
    input  logic                       pan_en,
    input  logic [15:0]                pan,
    input  logic                       flag_clr,
    output logic [W-1:0]               ldata,
    output logic [W-1:0]               rdata,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun
);

    localparam int PROD_W     = W + GAIN_W + 1;
    localparam int ACC_W      = PROD_W + $clog2(N_VOICES);
    localparam int IDX_W      = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    // signed W-bit sample times a 17-bit zero-extended pan weight fits W+16 bits
    localparam int PAN_PROD_W = W + 16;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VOICES - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2,
        ST_PAN   = 2'd3
    } state_t;

    // Clamp a scaled sum to W bits; the MSB of the result flags that clamping happened.
    function automatic logic [W:0] clamp_sample(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[W-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[W-1:0]};
        end else begin
            return {1'b0, v[W-1:0]};
        end
    endfunction

    state_t                      state_r, state_next_s;
    logic [N_VOICES*W-1:0]       voice_snap_r;
    logic [N_VOICES*GAIN_W-1:0]  gain_snap_r;
    logic                        pan_en_r;
    logic [15:0]                 pan_r;
    logic signed [ACC_W-1:0]     acc_r;
    logic [IDX_W-1:0]            idx_r;
    logic [W-1:0]                mixed_r;

    logic [W-1:0]                voice_sel_s;
    logic [GAIN_W-1:0]           gain_sel_s;
    logic signed [PROD_W-1:0]    voice_ext_s, gain_ext_s, prod_s;
    logic signed [ACC_W-1:0]     scaled_s;
    logic [W:0]                  clamp_s;
    logic [15:0]                 pan_inv_s;
    logic signed [PAN_PROD_W-1:0] mixed_ext_s, lgain_ext_s, rgain_ext_s, lprod_s, rprod_s;
    logic [W-1:0]                lpan_s, rpan_s;
    logic                        clip_set_s, overrun_set_s;
    logic                        unused_s;

    // Shared multiplier: current captured voice times its gain (gain treated as unsigned).
    always_comb begin
        voice_sel_s = voice_snap_r[int'(idx_r)*W +: W];
        gain_sel_s  = gain_snap_r[int'(idx_r)*GAIN_W +: GAIN_W];
        voice_ext_s = PROD_W'($signed(voice_sel_s));
        gain_ext_s  = $signed(PROD_W'({1'b0, gain_sel_s}));
        prod_s      = voice_ext_s * gain_ext_s;
    end

    // Scale back by the gain fraction (arithmetic shift floors) and saturate.
    always_comb begin
        scaled_s   = acc_r >>> GAIN_W;
        clamp_s    = clamp_sample(scaled_s);
        clip_set_s = (state_r == ST_SAT) && clamp_s[W];
    end

    // Linear pan: left weight is the complement of the pan position.
    always_comb begin
        pan_inv_s   = 16'hFFFF - pan_r;
        mixed_ext_s = PAN_PROD_W'($signed(mixed_r));
        lgain_ext_s = $signed(PAN_PROD_W'({1'b0, pan_inv_s}));
        rgain_ext_s = $signed(PAN_PROD_W'({1'b0, pan_r}));
        lprod_s     = mixed_ext_s * lgain_ext_s;
        rprod_s     = mixed_ext_s * rgain_ext_s;
        if (pan_en_r) begin
            lpan_s = lprod_s[16 +: W];
            rpan_s = rprod_s[16 +: W];
        end else begin
            lpan_s = mixed_r;
            rpan_s = mixed_r;
        end
        // fractional bits discarded by the >>>16
        unused_s = ^{lprod_s[15:0], rprod_s[15:0]};
    end

    // Next-state logic for the mix sequencer.
    always_comb begin
        state_next_s  = state_r;
        overrun_set_s = sample_strobe && (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (idx_r == IDX_LAST) begin
                    state_next_s = ST_SAT;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_SAT:  state_next_s = ST_PAN;
            ST_PAN:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, snapshot, accumulator and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= ST_IDLE;
            voice_snap_r <= '0;
            gain_snap_r  <= '0;
            pan_en_r     <= 1'b0;
            pan_r        <= 16'h0000;
            acc_r        <= '0;
            idx_r        <= '0;
            mixed_r      <= '0;
            ldata        <= '0;
            rdata        <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            busy      <= (state_next_s != ST_IDLE);
            out_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sample_strobe) begin
                        voice_snap_r <= voice_in;
                        gain_snap_r  <= gain_in;
                        pan_en_r     <= pan_en;
                        pan_r        <= pan;
                        acc_r        <= '0;
                        idx_r        <= '0;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_ACCUM: begin
                    acc_r <= acc_r + ACC_W'(prod_s);
                    idx_r <= idx_r + IDX_ONE;
                end
                ST_SAT: begin
                    mixed_r <= clamp_s[W-1:0];
                end
                ST_PAN: begin
                    ldata     <= lpan_s;
                    rdata     <= rpan_s;
                    out_valid <= 1'b1;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status flags; a set event in the same cycle beats flag_clr.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clip    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (clip_set_s) begin
                clip <= 1'b1;
            end else if (flag_clr) begin
                clip <= 1'b0;
            end else begin
                clip <= clip;
            end
            if (overrun_set_s) begin
                overrun <= 1'b1;
            end else if (flag_clr) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: table of directed mixes plus
// hand-written sequences for reset, overrun/snapshot and back-to-back strobes.
module tb_voice_mixer;

    logic         Clk;
    logic         Reset_n;
    logic         sample_strobe;
    logic [127:0] voice_in;
    logic [127:0] gain_in;
    logic         pan_en;
    logic [15:0]  pan;
    logic         flag_clr;
    logic [15:0]  ldata, rdata;
    logic         out_valid, busy, clip, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    voice_mixer #(.N_VOICES(8), .W(16), .GAIN_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .sample_strobe(sample_strobe),
        .voice_in(voice_in), .gain_in(gain_in), .pan_en(pan_en), .pan(pan),
        .flag_clr(flag_clr), .ldata(ldata), .rdata(rdata),
        .out_valid(out_valid), .busy(busy), .clip(clip), .overrun(overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string        name;
        logic [127:0] v;
        logic [127:0] g;
        logic         pe;
        logic [15:0]  p;
        logic         clr;
        logic [15:0]  el;
        logic [15:0]  er;
        logic         ec;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at 1 time unit after a rising edge.
    task automatic pulse_clr();
        flag_clr = 1'b1;
        @(posedge Clk); #1;
        flag_clr = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; returns clocks from strobe edge to out_valid.
    task automatic wait_valid(input int start_k, output int lat);
        lat = -1;
        for (int k = start_k; k <= 20 && lat < 0; k++) begin
            @(posedge Clk); #1;
            if (out_valid) lat = k;
        end
    endtask

    task automatic run_mix(input logic [127:0] v, input logic [127:0] g,
                           input logic pe, input logic [15:0] p, output int lat);
        voice_in = v; gain_in = g; pan_en = pe; pan = p;
        sample_strobe = 1'b1;
        @(posedge Clk); #1;
        sample_strobe = 1'b0;
        // scramble inputs: only the snapshot may matter
        voice_in = ~v; gain_in = ~g; pan_en = ~pe; pan = ~p;
        wait_valid(1, lat);
    endtask

    task automatic count_idle_valids(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge Clk); #1;
            if (out_valid) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        logic [127:0] v_unity, g_unity;

        v_unity = {{7{16'h0000}}, 16'h4000};
        g_unity = {{7{16'h0000}}, 16'hFFFF};

        vecs[0] = '{"unity",    v_unity, g_unity, 1'b0, 16'h0000, 1'b0, 16'h3FFF, 16'h3FFF, 1'b0};
        vecs[1] = '{"sat_pos",  {8{16'h7FFF}}, {8{16'hFFFF}}, 1'b0, 16'h0000, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[2] = '{"sat_neg",  {8{16'h8000}}, {8{16'hFFFF}}, 1'b0, 16'h0000, 1'b1, 16'h8000, 16'h8000, 1'b1};
        vecs[3] = '{"zero_gain",{8{16'h8000}}, {8{16'h0000}}, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{"pan_mid",  v_unity, g_unity, 1'b1, 16'h8000, 1'b1, 16'h1FFF, 16'h1FFF, 1'b0};
        vecs[5] = '{"pan_left", v_unity, g_unity, 1'b1, 16'h0000, 1'b0, 16'h3FFE, 16'h0000, 1'b0};
        vecs[6] = '{"pan_right",v_unity, g_unity, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h3FFE, 1'b0};
        // -16384*0xFFFF>>>16 floors to -16384; half pan floors -8191.75 to -8192
        vecs[7] = '{"pan_neg",  {{7{16'h0000}}, 16'hC000}, g_unity, 1'b1, 16'h8000, 1'b0, 16'hE000, 16'hE000, 1'b0};
        // 4096*0x8000 - 4096*0x4000 + 256*0xFFFF = 83885824; >>>16 floors to 1279
        vecs[8] = '{"multi",    {16'h0100, {5{16'h0000}}, 16'hF000, 16'h1000},
                                {16'hFFFF, {5{16'h0000}}, 16'h4000, 16'h8000},
                                1'b0, 16'h0000, 1'b0, 16'h04FF, 16'h04FF, 1'b0};

        Reset_n = 1'b1; sample_strobe = 1'b0; voice_in = '0; gain_in = '0;
        pan_en = 1'b0; pan = 16'h0000; flag_clr = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_ldata", 32'(ldata), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_clip", 32'(clip), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        count_idle_valids(15, cnt);
        chk("idle_no_valid", 32'(cnt), 32'h0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].clr) pulse_clr();
            run_mix(vecs[i].v, vecs[i].g, vecs[i].pe, vecs[i].p, lat);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd10);
            chk({vecs[i].name, "_ldata"}, 32'(ldata), 32'(vecs[i].el));
            chk({vecs[i].name, "_rdata"}, 32'(rdata), 32'(vecs[i].er));
            chk({vecs[i].name, "_clip"}, 32'(clip), 32'(vecs[i].ec));
            @(posedge Clk); #1;
            chk({vecs[i].name, "_hold"}, 32'(ldata), 32'(vecs[i].el));
        end

        // Overrun: second strobe 3 cycles into a mix is ignored and flagged.
        chk("ovr_pre", 32'(overrun), 32'h0);
        voice_in = v_unity; gain_in = g_unity; pan_en = 1'b0; pan = 16'h0000;
        sample_strobe = 1'b1;
        @(posedge Clk); #1;
        sample_strobe = 1'b0;
        chk("busy_in_mix", 32'(busy), 32'h1);
        repeat (3) @(posedge Clk);
        #1;
        voice_in = {{7{16'h0000}}, 16'h1000};
        sample_strobe = 1'b1;
        @(posedge Clk); #1;
        sample_strobe = 1'b0;
        chk("ovr_set", 32'(overrun), 32'h1);
        wait_valid(5, lat);
        chk("ovr_lat", 32'(lat), 32'd10);
        chk("ovr_ldata", 32'(ldata), 32'h3FFF);
        // strobe in the out_valid cycle is accepted; voice0 is now 0x1000
        sample_strobe = 1'b1;
        @(posedge Clk); #1;
        sample_strobe = 1'b0;
        chk("b2b_valid_low", 32'(out_valid), 32'h0);
        wait_valid(1, lat);
        chk("b2b_lat", 32'(lat), 32'd10);
        chk("b2b_ldata", 32'(ldata), 32'h0FFF);
        chk("b2b_overrun_still", 32'(overrun), 32'h1);
        pulse_clr();
        chk("ovr_clr", 32'(overrun), 32'h0);

        // Overrun set coinciding with flag_clr: set wins.
        voice_in = v_unity; gain_in = g_unity;
        sample_strobe = 1'b1;
        @(posedge Clk); #1;
        flag_clr = 1'b1;
        @(posedge Clk); #1;
        sample_strobe = 1'b0; flag_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'h1);
        wait_valid(2, lat);
        chk("ovr_wins_lat", 32'(lat), 32'd10);

        // Reset in the middle of a mix.
        voice_in = v_unity; gain_in = g_unity; pan_en = 1'b0;
        sample_strobe = 1'b1;
        @(posedge Clk); #1;
        sample_strobe = 1'b0;
        repeat (4) @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ldata", 32'(ldata), 32'h0);
        chk("mid_rst_rdata", 32'(rdata), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        count_idle_valids(15, cnt);
        chk("mid_rst_no_valid", 32'(cnt), 32'h0);
        run_mix(v_unity, g_unity, 1'b0, 16'h0000, lat);
        chk("post_rst_lat", 32'(lat), 32'd10);
        chk("post_rst_ldata", 32'(ldata), 32'h3FFF);
        chk("post_rst_rdata", 32'(rdata), 32'h3FFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
